// File: rtl/byte_striping_pkg.sv
// Constants and selector encoding shared by the striping stage, the unstriping stage and benches.
package byte_striping_pkg;
  localparam int STRIPE_DATA_W = 32;
  localparam int STRIPE_CNT_W  = 8;
  localparam int NUM_LANES     = 2;

  typedef enum logic {
    SEL0 = 1'b0,
    SEL1 = 1'b1
  } sel_e;
endpackage

// File: rtl/stripe_lane_reg.sv
// One output lane: data, valid and a word counter, updated only when this lane is loaded.
// One-cycle latency; valid drops on any cycle without a load. No backpressure.
module stripe_lane_reg
  import byte_striping_pkg::*;
#(
  parameter int DATA_W = STRIPE_DATA_W,
  parameter int CNT_W  = STRIPE_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] lane,
  output logic              vld,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              vld_q, vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // data_in is only looked at under load, so an X on an idle cycle never reaches data_q.
  always_comb begin
    data_d = data_q;
    vld_d  = 1'b0;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = data_in;
      vld_d  = 1'b1;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lane  = data_q;
  assign vld   = vld_q;
  assign count = cnt_q;

endmodule

// File: rtl/byte_striping.sv
// Alternates consecutive valid input words onto lane 0 / lane 1, one-cycle registered latency.
// No backpressure: every valid input cycle is accepted and must be consumed downstream.
module byte_striping
  import byte_striping_pkg::*;
#(
  parameter int DATA_W = STRIPE_DATA_W,
  parameter int CNT_W  = STRIPE_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] lane_0,
  output logic              valid_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_1,
  output logic [CNT_W-1:0]  count_0,
  output logic [CNT_W-1:0]  count_1,
  output logic              next_lane
);

  sel_e state_q, state_d;
  logic load_0, load_1;

  // Idle cycles hold the selector, so an odd burst leaves the next word on lane 1.
  always_comb begin
    state_d = state_q;
    if (valid_in) begin
      state_d = (state_q == SEL0) ? SEL1 : SEL0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEL0;
    end else begin
      state_q <= state_d;
    end
  end

  assign load_0    = valid_in && (state_q == SEL0);
  assign load_1    = valid_in && (state_q == SEL1);
  assign next_lane = state_q;

  stripe_lane_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane_0 (
    .clk     (clk),
    .reset   (reset),
    .load    (load_0),
    .data_in (data_in),
    .lane    (lane_0),
    .vld     (valid_0),
    .count   (count_0)
  );

  stripe_lane_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane_1 (
    .clk     (clk),
    .reset   (reset),
    .load    (load_1),
    .data_in (data_in),
    .lane    (lane_1),
    .vld     (valid_1),
    .count   (count_1)
  );

endmodule

// File: doc/byte_striping.md
Name: byte_striping

Overview:
- Upstream neighbour of the byte-unstriping stage.
- Accepts a single 32-bit word stream with valid and distributes consecutive valid words alternately onto two 32-bit lanes: lane_0 first, then lane_1, then lane_0 again.
- Outputs are registered and carry one valid qualifier per lane.
- Per-lane word counters let benches check that the downstream unstriper consumes a balanced stream.

Parameters:
- DATA_W, 32, width of the input word and of each lane.
- CNT_W, 8, width of each per-lane word counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  DATA_W  word to stripe; sampled only when valid_in=1.
- valid_in  input  1  data_in qualifier.
- lane_0  output  DATA_W  lane 0 data, registered.
- valid_0  output  1  lane_0 holds a new word this cycle.
- lane_1  output  DATA_W  lane 1 data, registered.
- valid_1  output  1  lane_1 holds a new word this cycle.
- count_0  output  CNT_W  words sent on lane 0 since reset.
- count_1  output  CNT_W  words sent on lane 1 since reset.
- next_lane  output  1  current selector state (0 = next word goes to lane 0); exported for the bench.

Behaviour:
- Reset:
  - Asserting reset (reset=0) immediately forces lane_0, lane_1, valid_0, valid_1, count_0, count_1 and next_lane to 0, regardless of clk.
  - Deassertion takes effect at the first rising edge with reset=1.
- State machine: two states, SEL0 (next_lane=0) and SEL1 (next_lane=1).
  - The reset state is SEL0.
  - On an edge with valid_in=1: SEL0 goes to SEL1, SEL1 goes to SEL0.
  - On an edge with valid_in=0: the state holds. A gap never realigns the selector, so an odd-length burst leaves the next word on lane_1.
- Datapath, 1-cycle latency. At an edge with valid_in=1:
  - In SEL0: lane_0<=data_in, valid_0<=1, valid_1<=0, count_0 increments, lane_1 holds.
  - In SEL1: lane_1<=data_in, valid_1<=1, valid_0<=0, count_1 increments, lane_0 holds.
- At an edge with valid_in=0: valid_0<=0, valid_1<=0; lane data and counters hold their values.
- At most one of valid_0/valid_1 is high in any cycle. Both low means idle.
- Counters:
  - Unsigned, wrap from 2^CNT_W-1 to 0 with no flag.
  - Invariant after any edge: count_0 - count_1 (mod 2^CNT_W) is 0 when next_lane=0 and 1 when next_lane=1.
- data_in is don't-care when valid_in=0; X on data_in must not propagate into lanes.
- Reset asserted mid-burst:
  - Outputs clear immediately.
  - The partially sent pair is abandoned.
  - The first valid word after release goes to lane_0.
- No backpressure: the downstream stage must accept every valid cycle.

Decomposition:
- Shared package (also used by the unstriping stage and the bench):
  - DATA_W default and the lane count constant NUM_LANES=2.
  - State encodings SEL0=1'b0, SEL1=1'b1.
- One natural sub-module, stripe_lane_reg: per-lane register holding data, valid and counter, with load enable. Instantiate it twice, steered by the selector.
- The selector FSM stays in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles with valid_in=1 and data_in=32'hFFFFFFFF -> all outputs 0, next_lane=0. Pulse reset=0 between clock edges -> outputs clear without waiting for an edge.
- Continuous burst: words 32'h00000001..32'h00000004 on consecutive cycles -> lane_0 carries 1, then 3; lane_1 carries 2, then 4. valid_0 and valid_1 alternate starting 1 cycle after the first word. Final count_0=2, count_1=2, next_lane=0.
- Odd burst with gap: send 32'hA, 32'hB, 32'hC, then 2 idle cycles, then 32'hD -> A→lane_0, B→lane_1, C→lane_0, D→lane_1. Both valids are 0 during the gap and lanes hold C and B. Ends with count_0=2, count_1=2.
- Reset mid-operation: send 32'h11, 32'h22, 32'h33, assert reset for 1 cycle, then send 32'h44 -> outputs clear during reset; 32'h44 appears on lane_0 with valid_0=1 and count_0=1.
- Counter wrap (CNT_W=8): 512 consecutive valid words -> count_0 and count_1 both wrap 255→0 and both end at 0; the counter invariant holds every cycle.
- Loopback: connect to the unstriping stage and send 100 random valid words with random gaps -> the unstriper output reproduces the input sequence in order. Checker compares both the behavioural and synthesized versions.
